// File: rtl/bridge_buffer_pkg.sv
// Shared types and helpers for the bridge ping-pong buffer sequencer.
package bridge_buffer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFetch,
        StServe
    } bbuf_state_e;

    // Width of a select into n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bridge_buffer_ctrl.sv
// Bank-0 sequencer for one bridge buffer: fills TOTAL_DEPTH words from the
// projection stage, then drains every word slice by slice to the systolic array.
module bridge_buffer_ctrl
    import bridge_buffer_pkg::*;
#(
    parameter int unsigned TOTAL_DEPTH   = 12,
    parameter int unsigned TOTAL_MODULES = 4,
    parameter int unsigned ADDR_WIDTH    = 8,
    localparam int unsigned SliceW       = idx_width(TOTAL_MODULES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  bank0_ena,
    output logic                  bank0_wea,
    output logic [ADDR_WIDTH-1:0] bank0_addra,
    output logic                  bank0_enb,
    output logic [ADDR_WIDTH-1:0] bank0_addrb,
    output logic [SliceW-1:0]     slicing_idx
);

    // Write counter carries one extra bit so the final increment cannot wrap.
    localparam logic [ADDR_WIDTH:0]   WrLast    = (ADDR_WIDTH + 1)'(TOTAL_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] RdLast    = ADDR_WIDTH'(TOTAL_DEPTH - 1);
    localparam logic [SliceW-1:0]     SliceLast = SliceW'(TOTAL_MODULES - 1);

    bbuf_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [SliceW-1:0]     rd_slice_q, rd_slice_d;
    logic                  done_q, done_d;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_slice_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_slice_q <= rd_slice_d;
            done_q     <= done_d;
        end
    end

    // Next-state, counter updates and per-state port control.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_slice_d  = rd_slice_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        bank0_ena   = 1'b0;
        bank0_wea   = 1'b0;
        bank0_addra = '0;
        bank0_enb   = 1'b0;
        out_valid   = 1'b0;
        slicing_idx = '0;
        case (state_q)
            StIdle: begin
                wr_cnt_d   = '0;
                rd_addr_d  = '0;
                rd_slice_d = '0;
                if (start) state_d = StFill;
            end
            StFill: begin
                in_ready    = 1'b1;
                bank0_ena   = in_valid;
                bank0_wea   = in_valid;
                bank0_addra = wr_cnt_q[ADDR_WIDTH-1:0];
                if (in_valid) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == WrLast) state_d = StFetch;
                end
            end
            StFetch: begin
                bank0_enb = 1'b1;
                state_d   = StServe;
            end
            StServe: begin
                // Read port stays off so the bank keeps dout stable across stalls.
                out_valid   = 1'b1;
                slicing_idx = rd_slice_q;
                if (out_ready) begin
                    if (rd_slice_q != SliceLast) begin
                        rd_slice_d = rd_slice_q + 1'b1;
                    end else if (rd_addr_q != RdLast) begin
                        rd_slice_d = '0;
                        rd_addr_d  = rd_addr_q + 1'b1;
                        state_d    = StFetch;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bank0_addrb = rd_addr_q;
    assign out_last    = (state_q == StServe) && (rd_addr_q == RdLast) &&
                         (rd_slice_q == SliceLast);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;

endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// Directed bench: D=12/M=4 instance driven by hand sequences, D=1/M=1
// instance driven from a vector table.
module tb_bridge_buffer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Large instance.
    logic       start = 0, in_valid = 0, out_ready = 0;
    logic       in_ready, out_valid, out_last, busy, done;
    logic       bank0_ena, bank0_wea, bank0_enb;
    logic [7:0] bank0_addra, bank0_addrb;
    logic [1:0] slicing_idx;

    bridge_buffer_ctrl #(.TOTAL_DEPTH(12), .TOTAL_MODULES(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .done(done), .bank0_ena(bank0_ena),
        .bank0_wea(bank0_wea), .bank0_addra(bank0_addra), .bank0_enb(bank0_enb),
        .bank0_addrb(bank0_addrb), .slicing_idx(slicing_idx)
    );

    // Degenerate instance.
    logic       s_start = 0, s_in_valid = 0, s_out_ready = 0;
    logic       s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
    logic       s_ena, s_wea, s_enb;
    logic [7:0] s_addra, s_addrb;
    logic [0:0] s_idx;

    bridge_buffer_ctrl #(.TOTAL_DEPTH(1), .TOTAL_MODULES(1), .ADDR_WIDTH(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_ready(s_out_ready), .out_valid(s_out_valid),
        .out_last(s_out_last), .busy(s_busy), .done(s_done), .bank0_ena(s_ena),
        .bank0_wea(s_wea), .bank0_addra(s_addra), .bank0_enb(s_enb),
        .bank0_addrb(s_addrb), .slicing_idx(s_idx)
    );

    function automatic logic [25:0] pk(bit ir, bit en, bit we, int aa, bit eb, int ab,
                                       bit ov, bit ol, bit by, bit dn, int ix);
        return {ir, en, we, 8'(aa), eb, 8'(ab), ov, ol, by, dn, 2'(ix)};
    endfunction

    function automatic logic [24:0] pks(bit ir, bit en, bit we, int aa, bit eb, int ab,
                                        bit ov, bit ol, bit by, bit dn, bit ix);
        return {ir, en, we, 8'(aa), eb, 8'(ab), ov, ol, by, dn, ix};
    endfunction

    function automatic logic [25:0] big_act();
        return {in_ready, bank0_ena, bank0_wea, bank0_addra, bank0_enb, bank0_addrb,
                out_valid, out_last, busy, done, slicing_idx};
    endfunction

    function automatic logic [24:0] small_act();
        return {s_in_ready, s_ena, s_wea, s_addra, s_enb, s_addrb,
                s_out_valid, s_out_last, s_busy, s_done, s_idx};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle on the large instance: drive at negedge, check, move to next negedge.
    task automatic cyc(input string nm, input bit st, input bit iv, input bit ordy,
                       input logic [25:0] exp);
        start = st; in_valid = iv; out_ready = ordy;
        #1;
        chk(nm, 64'(big_act()), 64'(exp));
        @(negedge clk);
    endtask

    // Full run from IDLE; returns just before the done cycle, or at (abort_a, 1).
    task automatic do_run(input bit gapped, input bit stall, input bit poke,
                          input bit pdone, input int pab, input int abort_a);
        int  i;
        bit  gap;
        bit  ol;
        cyc("start", 1, 0, 1, pk(0, 0, 0, 0, 0, pab, 0, 0, 0, pdone, 0));
        i = 0;
        gap = 0;
        while (i < 12) begin
            if (gapped && gap) begin
                cyc($sformatf("fill_gap%0d", i), 0, 0, 1, pk(1, 0, 0, i, 0, 0, 0, 0, 1, 0, 0));
            end else begin
                cyc($sformatf("fill%0d", i), poke && (i == 3), 1, 1,
                    pk(1, 1, 1, i, 0, 0, 0, 0, 1, 0, 0));
                i++;
            end
            gap = !gap;
        end
        for (int a = 0; a < 12; a++) begin
            cyc($sformatf("fetch%0d", a), 0, 1, 1, pk(0, 0, 0, 0, 1, a, 0, 0, 1, 0, 0));
            for (int s = 0; s < 4; s++) begin
                if (a == abort_a && s == 1) return;
                ol = (a == 11) && (s == 3);
                if (stall && a == 5 && s == 2) begin
                    repeat (3) cyc($sformatf("stall a%0d s%0d", a, s), 1, 0, 0,
                                   pk(0, 0, 0, 0, 0, a, 1, ol, 1, 0, s));
                end
                cyc($sformatf("slice a%0d s%0d", a, s), poke && a == 2 && s == 1, 0, 1,
                    pk(0, 0, 0, 0, 0, a, 1, ol, 1, 0, s));
            end
        end
    endtask

    typedef struct {
        bit          st;
        bit          iv;
        bit          ordy;
        logic [24:0] exp;
    } svec_t;

    svec_t tbl[13];

    initial begin
        tbl[0]  = '{0, 0, 0, pks(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1, 0, 0, pks(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{0, 1, 0, pks(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[3]  = '{0, 1, 0, pks(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0)};
        tbl[4]  = '{0, 0, 0, pks(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)};
        tbl[5]  = '{0, 0, 1, pks(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)};
        tbl[6]  = '{1, 0, 0, pks(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[7]  = '{0, 0, 0, pks(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[8]  = '{0, 1, 0, pks(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[9]  = '{0, 0, 0, pks(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0)};
        tbl[10] = '{0, 0, 1, pks(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)};
        tbl[11] = '{0, 0, 0, pks(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[12] = '{0, 0, 0, pks(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_big", 64'(big_act()), 64'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        chk("reset_small", 64'(small_act()), 64'(pks(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle", 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Basic run, then back-to-back run with start pokes during FILL/SERVE.
        do_run(0, 0, 0, 0, 0, -1);
        do_run(0, 0, 1, 1, 11, -1);
        cyc("done2", 0, 0, 1, pk(0, 0, 0, 0, 0, 11, 0, 0, 0, 1, 0));
        cyc("idle2", 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Gapped fill with a 3-cycle stall at (addr 5, slice 2).
        do_run(1, 1, 0, 0, 0, -1);
        cyc("done3", 0, 0, 1, pk(0, 0, 0, 0, 0, 11, 0, 0, 0, 1, 0));
        cyc("idle3", 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in the middle of the drain at (addr 7, slice 1).
        do_run(0, 0, 0, 0, 0, 7);
        start = 0; in_valid = 0; out_ready = 1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 64'(big_act()), 64'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle_post_rst", 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        do_run(0, 0, 0, 0, 0, -1);
        cyc("done4", 0, 0, 1, pk(0, 0, 0, 0, 0, 11, 0, 0, 0, 1, 0));

        // Degenerate D=1, M=1 instance from the vector table.
        for (int i = 0; i < 13; i++) begin
            s_start = tbl[i].st; s_in_valid = tbl[i].iv; s_out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("small[%0d]", i), 64'(small_act()), 64'(tbl[i].exp));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
